// File: rtl/tron_pkg.sv
// Shared direction type, encodings and helpers for the player direction controller.
package tron_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    function automatic dir_t dir_reverse(input dir_t d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/player_dir_chan.sv
// One player channel: pending turn storage, reverse-turn rejection and wrapping move.
// Define TURN_QUEUE_EN for a 2-deep turn FIFO; default is a single overwrite slot.
module player_dir_chan
    import tron_pkg::*;
#(
    parameter int unsigned COORD_W  = 8,
    parameter int unsigned GRID_W   = 160,
    parameter int unsigned GRID_H   = 120,
    parameter int unsigned INIT_X   = 0,
    parameter int unsigned INIT_Y   = 0,
    parameter dir_t        INIT_DIR = DIR_UP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               turn_req,
    input  dir_t               turn_dir,
    output dir_t               dir,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               turn_rej
);

    logic               pop_c;
    logic               rev_c;
    logic               rej_c;
    dir_t               head_c;
    dir_t               dir_c;
    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;

`ifdef TURN_QUEUE_EN
    logic [1:0] q_cnt;
    dir_t       q_mem [2];
    logic       push_c;
    logic       full_c;

    // Fullness is judged on the count before this cycle's pop.
    always_comb begin
        full_c = (q_cnt == 2'd2);
        pop_c  = step && (q_cnt != 2'd0);
        push_c = turn_req && !full_c;
        head_c = q_mem[0];
        rev_c  = pop_c && (head_c == dir_reverse(dir));
        rej_c  = rev_c || (turn_req && full_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_cnt    <= 2'd0;
            q_mem[0] <= DIR_UP;
            q_mem[1] <= DIR_UP;
        end else begin
            case ({push_c, pop_c})
                2'b10: begin
                    q_mem[q_cnt[0]] <= turn_dir;
                    q_cnt           <= q_cnt + 2'd1;
                end
                2'b01: begin
                    q_mem[0] <= q_mem[1];
                    q_cnt    <= q_cnt - 2'd1;
                end
                2'b11: q_mem[0] <= turn_dir;
                default: ;
            endcase
        end
    end
`else
    logic pend_v;
    dir_t pend_d;

    always_comb begin
        pop_c  = step && pend_v;
        head_c = pend_d;
        rev_c  = pop_c && (pend_d == dir_reverse(dir));
        rej_c  = rev_c;
    end

    // A fresh request always wins over consuming the old one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v <= 1'b0;
            pend_d <= DIR_UP;
        end else if (turn_req) begin
            pend_v <= 1'b1;
            pend_d <= turn_dir;
        end else if (pop_c) begin
            pend_v <= 1'b0;
        end
    end
`endif

    // Post-turn direction and wrapped next cell.
    always_comb begin
        dir_c = (pop_c && !rev_c) ? head_c : dir;
        x_c   = x;
        y_c   = y;
        case (dir_c)
            DIR_UP:    y_c = (y == '0) ? COORD_W'(GRID_H - 1) : y - COORD_W'(1);
            DIR_DOWN:  y_c = (y == COORD_W'(GRID_H - 1)) ? '0 : y + COORD_W'(1);
            DIR_LEFT:  x_c = (x == '0) ? COORD_W'(GRID_W - 1) : x - COORD_W'(1);
            default:   x_c = (x == COORD_W'(GRID_W - 1)) ? '0 : x + COORD_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir      <= INIT_DIR;
            x        <= COORD_W'(INIT_X);
            y        <= COORD_W'(INIT_Y);
            turn_rej <= 1'b0;
        end else begin
            turn_rej <= rej_c;
            if (step) begin
                dir <= dir_c;
                x   <= x_c;
                y   <= y_c;
            end
        end
    end

endmodule

// File: rtl/player_dir_ctrl.sv
// Multi-player direction/position controller with a shared move-step tick.
// Define TURN_QUEUE_EN to give every player a 2-deep turn FIFO.
module player_dir_ctrl
    import tron_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned COORD_W     = 8,
    parameter int unsigned GRID_W      = 160,
    parameter int unsigned GRID_H      = 120,
    parameter int unsigned TICK_DIV    = 833333
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_PLAYERS-1:0]         turn_req,
    input  logic [2*NUM_PLAYERS-1:0]       turn_dir,
    output logic [2*NUM_PLAYERS-1:0]       dir_out,
    output logic [COORD_W*NUM_PLAYERS-1:0] pos_x,
    output logic [COORD_W*NUM_PLAYERS-1:0] pos_y,
    output logic                           step,
    output logic [NUM_PLAYERS-1:0]         turn_rej
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Reset masks the step so no channel sees a move in a reset cycle.
    assign step = enable && !reset && (cnt == CNT_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_chan
        player_dir_chan #(
            .COORD_W  (COORD_W),
            .GRID_W   (GRID_W),
            .GRID_H   (GRID_H),
            .INIT_X   ((2 * i + 1) * GRID_W / (2 * NUM_PLAYERS)),
            .INIT_Y   (GRID_H / 2),
            .INIT_DIR ((i % 2 == 0) ? DIR_DOWN : DIR_UP)
        ) u_chan (
            .clk      (CLOCK_50),
            .reset    (reset),
            .step     (step),
            .turn_req (turn_req[i]),
            .turn_dir (turn_dir[2*i +: 2]),
            .dir      (dir_out[2*i +: 2]),
            .x        (pos_x[COORD_W*i +: COORD_W]),
            .y        (pos_y[COORD_W*i +: COORD_W]),
            .turn_rej (turn_rej[i])
        );
    end

endmodule

// File: tb/tb_player_dir_ctrl.sv
// Randomized bench for player_dir_ctrl against a per-cycle arithmetic reference model.
module tb_player_dir_ctrl;

    localparam int NP = 2;
    localparam int CW = 8;
    localparam int GW = 160;
    localparam int GH = 120;
    localparam int TD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NP-1:0]     turn_req;
    logic [2*NP-1:0]   turn_dir;
    logic [2*NP-1:0]   dir_out;
    logic [CW*NP-1:0]  pos_x;
    logic [CW*NP-1:0]  pos_y;
    logic              step;
    logic [NP-1:0]     turn_rej;

    always #5 clk = ~clk;

    player_dir_ctrl #(
        .NUM_PLAYERS (NP),
        .COORD_W     (CW),
        .GRID_W      (GW),
        .GRID_H      (GH),
        .TICK_DIV    (TD)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .enable   (enable),
        .turn_req (turn_req),
        .turn_dir (turn_dir),
        .dir_out  (dir_out),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .step     (step),
        .turn_rej (turn_rej)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: plain integers, pending turns as a small list per player.
    int m_cnt;
    int m_dir [NP];
    int m_x   [NP];
    int m_y   [NP];
    int m_qn  [NP];
    int m_qd  [NP][2];
    bit m_rej [NP];
    bit last_step;

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < NP; i++) begin
            m_dir[i] = (i % 2 == 0) ? 2 : 0;
            m_x[i]   = (2 * i + 1) * GW / (2 * NP);
            m_y[i]   = GH / 2;
            m_qn[i]  = 0;
            m_rej[i] = 1'b0;
        end
    endtask

    task automatic model_clock(input bit r, input bit en, input logic [NP-1:0] req,
                               input logic [2*NP-1:0] td);
        bit s;
        bit full;
        int d;
        if (r) begin
            model_reset();
            return;
        end
        s = en && (m_cnt == TD - 1);
        if (en) m_cnt = (m_cnt + 1) % TD;
        for (int i = 0; i < NP; i++) begin
            m_rej[i] = 1'b0;
            full = (m_qn[i] == 2);
            if (s) begin
                if (m_qn[i] > 0) begin
                    d = m_qd[i][0];
                    m_qd[i][0] = m_qd[i][1];
                    m_qn[i]--;
                    if (d == (m_dir[i] + 2) % 4) m_rej[i] = 1'b1;
                    else m_dir[i] = d;
                end
                case (m_dir[i])
                    0: m_y[i] = (m_y[i] + GH - 1) % GH;
                    1: m_x[i] = (m_x[i] + 1) % GW;
                    2: m_y[i] = (m_y[i] + 1) % GH;
                    default: m_x[i] = (m_x[i] + GW - 1) % GW;
                endcase
            end
            if (req[i]) begin
                d = int'(td[2*i +: 2]);
`ifdef TURN_QUEUE_EN
                if (full) m_rej[i] = 1'b1;
                else begin
                    m_qd[i][m_qn[i]] = d;
                    m_qn[i]++;
                end
`else
                m_qd[i][0] = d;
                m_qn[i] = 1;
`endif
            end
        end
    endtask

    // One clock: drive, check step, clock, check registered outputs.
    task automatic cycle(input bit r, input bit en, input logic [NP-1:0] req,
                         input logic [2*NP-1:0] td);
        bit exp_step;
        logic [2*NP-1:0]  ed;
        logic [CW*NP-1:0] ex;
        logic [CW*NP-1:0] ey;
        logic [NP-1:0]    er;
        reset    = r;
        enable   = en;
        turn_req = req;
        turn_dir = td;
        #1;
        exp_step = !r && en && (m_cnt == TD - 1);
        check("step", 32'(step), 32'(exp_step));
        last_step = exp_step;
        @(posedge clk);
        model_clock(r, en, req, td);
        #1;
        for (int i = 0; i < NP; i++) begin
            ed[2*i +: 2]  = 2'(m_dir[i]);
            ex[CW*i +: CW] = CW'(m_x[i]);
            ey[CW*i +: CW] = CW'(m_y[i]);
            er[i]          = m_rej[i];
        end
        check("dir_out", 32'(dir_out), 32'(ed));
        check("pos_x", 32'(pos_x), 32'(ex));
        check("pos_y", 32'(pos_y), 32'(ey));
        check("turn_rej", 32'(turn_rej), 32'(er));
    endtask

    task automatic run_to_step();
        last_step = 1'b0;
        for (int k = 0; k < 4 * TD && !last_step; k++) cycle(1'b0, 1'b1, '0, '0);
        if (!last_step) check("step_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, '0, '0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dir"},   32'(dir_out), 32'h2);
        check({tag, "_pos_x"}, 32'(pos_x),   32'h7828);
        check({tag, "_pos_y"}, 32'(pos_y),   32'h3C3C);
        check({tag, "_rej"},   32'(turn_rej), 32'h0);
    endtask

    initial begin
        model_reset();
        last_step = 1'b0;

        do_reset();
        check_reset_values("rst");

        // Reverse request is rejected, then a legal turn applies.
        cycle(1'b0, 1'b1, 2'b01, 4'b0000);
        run_to_step();
        check("rev_rej", 32'(turn_rej[0]), 32'd1);
        check("rev_dir", 32'(dir_out[1:0]), 32'd2);
        check("rev_y", 32'(pos_y[7:0]), 32'd61);
        cycle(1'b0, 1'b1, 2'b01, 4'b0001);
        run_to_step();
        check("turn_dir", 32'(dir_out[1:0]), 32'd1);
        check("turn_x", 32'(pos_x[7:0]), 32'd41);

        // Vertical wrap on both edges.
        do_reset();
        for (int k = 0; k < 61; k++) run_to_step();
        check("wrap_up", 32'(pos_y[15:8]), 32'd119);
        check("wrap_down", 32'(pos_y[7:0]), 32'd1);

        // Horizontal wrap at the right edge.
        cycle(1'b0, 1'b1, 2'b01, 4'b0001);
        run_to_step();
        for (int k = 0; k < 118; k++) run_to_step();
        check("edge_x", 32'(pos_x[7:0]), 32'd159);
        run_to_step();
        check("wrap_right", 32'(pos_x[7:0]), 32'd0);

        // Reset on a step cycle drops the pending turn.
        do_reset();
        cycle(1'b0, 1'b1, 2'b01, 4'b0001);
        for (int k = 0; k < 2 * TD && m_cnt != TD - 1; k++) cycle(1'b0, 1'b1, '0, '0);
        cycle(1'b1, 1'b1, '0, '0);
        check_reset_values("rst_step");
        run_to_step();
        check("lost_turn_dir", 32'(dir_out[1:0]), 32'd2);
        check("lost_turn_y", 32'(pos_y[7:0]), 32'd61);

`ifdef TURN_QUEUE_EN
        // Third queued request overflows the 2-deep FIFO.
        do_reset();
        run_to_step();
        cycle(1'b0, 1'b1, 2'b01, 4'b0001);
        cycle(1'b0, 1'b1, 2'b01, 4'b0000);
        cycle(1'b0, 1'b1, 2'b01, 4'b0011);
        check("fifo_full_rej", 32'(turn_rej[0]), 32'd1);
        run_to_step();
        check("fifo_first", 32'(dir_out[1:0]), 32'd1);
        run_to_step();
        check("fifo_second", 32'(dir_out[1:0]), 32'd0);
`endif

        // Random traffic including enable gaps and occasional resets.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            logic [NP-1:0]   rq;
            logic [2*NP-1:0] rd;
            bit              r;
            bit              en;
            r  = ($urandom % 300) == 0;
            en = ($urandom % 6) != 0;
            for (int i = 0; i < NP; i++) rq[i] = ($urandom % 4) == 0;
            rd = (2*NP)'($urandom);
            cycle(r, en, rq, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
